uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 156 +++++++++++++++
 tb/tb_uart_tx_framer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit.
module uart_tx_framer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 5,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              parity_odd,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BAUD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     baud_cnt, baud_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              tx_q, tx_n;
  logic              last_baud, stop_last, accept;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_n;
`else
  logic unused_parity;
  assign unused_parity = parity_odd;
`endif

  assign last_baud = (baud_cnt == LAST_BAUD);
  assign stop_last = (state == STOP) && last_baud && (bit_cnt == LAST_STOP);
  assign tx_ready  = (state == IDLE) || stop_last;
  assign accept    = tx_valid && tx_ready;
  assign tx_busy   = (state != IDLE);
  assign tx_done   = stop_last;
  assign tx        = tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_n;
`endif
    end
  end

  // tx is registered: the value for the next bit is chosen at the bit boundary.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    tx_n    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    if (state != IDLE) baud_n = last_baud ? '0 : baud_cnt + 1'b1;

    case (state)
      IDLE: tx_n = 1'b1;
      START: begin
        if (last_baud) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (last_baud) begin
          if (bit_cnt == LAST_DATA) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n   = bit_cnt + 1'b1;
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last_baud) begin
          state_n = STOP;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (last_baud) begin
          if (bit_cnt == LAST_STOP) begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // Acceptance overrides the STOP->IDLE return so back-to-back frames have no gap.
    if (accept) begin
      state_n = START;
      baud_n  = '0;
      bit_n   = '0;
      tx_n    = 1'b0;
      shreg_n = tx_data;
`ifdef UART_TX_PARITY_EN
      par_n   = (^tx_data) ^ parity_odd;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: two instances (8N1-style and 7-bit/2-stop), CLKS_PER_BIT=4.
module tb_uart_tx_framer;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0, a_podd = 1'b0;
  logic       a_ready, a_tx, a_busy, a_done;
  logic [6:0] b_data = '0;
  logic       b_valid = 1'b0, b_podd = 1'b0;
  logic       b_ready, b_tx, b_busy, b_done;

  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .parity_odd(a_podd), .tx(a_tx), .tx_busy(a_busy), .tx_done(a_done));

  uart_tx_framer #(.DATA_W(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .parity_odd(b_podd), .tx(b_tx), .tx_busy(b_busy), .tx_done(b_done));

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [15:0] frame;
    int          nbits;
    longint      acc_t;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int          k[2];
  logic [15:0] cap[2];
  bit          unstable[2];
  bit          rdy_bad[2];
  int          dones[2];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Serial frame, bit 0 first on the line: start, data LSB first, [parity], stop bits.
  function automatic logic [15:0] build(input logic [8:0] d, input int dw, input logic p,
                                        input int stops, output int n);
    logic [15:0] f;
    int pos;
    f = '0;
    pos = 1;
    for (int i = 0; i < dw; i++) begin f[pos] = d[i]; pos++; end
    if (PAR == 1) begin f[pos] = p; pos++; end
    for (int s = 0; s < stops; s++) begin f[pos] = 1'b1; pos++; end
    n = pos;
    return f;
  endfunction

  task automatic clear_mon(input int ch);
    k[ch] = 0; cap[ch] = '0; unstable[ch] = 1'b0; rdy_bad[ch] = 1'b0;
  endtask

  task automatic mon_step(input int ch, input logic txv, input logic busy, input logic done,
                          input logic rdy);
    int   b, idx;
    exp_t e;
    if (busy) begin
      b = k[ch] / CPB;
      if (b < 16) begin
        if (k[ch] % CPB == 0) cap[ch][b] = txv;
        else if (txv !== cap[ch][b]) unstable[ch] = 1'b1;
      end
      if (rdy !== done) rdy_bad[ch] = 1'b1;
      k[ch]++;
    end
    if (done) begin
      dones[ch]++;
      idx = -1;
      foreach (sb[i]) if (idx < 0 && sb[i].ch == ch) idx = i;
      checks++;
      if (idx < 0) begin
        errors++;
        $display("FAIL spurious_done: ch%0d tx_done with no frame expected at %0t", ch, $time);
      end else begin
        e = sb[idx];
        sb.delete(idx);
        check($sformatf("frame_bits_ch%0d", ch), cap[ch], e.frame);
        check($sformatf("frame_cycles_ch%0d", ch), k[ch], e.nbits * CPB);
        check($sformatf("done_latency_ch%0d", ch), (longint'($time) - e.acc_t + 5) / 10,
              e.nbits * CPB);
        check($sformatf("bit_stable_ch%0d", ch), unstable[ch], 0);
        check($sformatf("ready_only_last_ch%0d", ch), rdy_bad[ch], 0);
      end
      clear_mon(ch);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      clear_mon(0);
      clear_mon(1);
    end else begin
      mon_step(0, a_tx, a_busy, a_done, a_ready);
      mon_step(1, b_tx, b_busy, b_done, b_ready);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic offer(input int ch, input logic [7:0] d, input logic podd, input logic par,
                       input bit keep, input bit expect_frame, output longint t);
    bit   acc, r;
    exp_t e;
    int   n;
    acc = 1'b0;
    t = 0;
    if (ch == 0) begin a_data = d; a_podd = podd; a_valid = 1'b1; end
    else begin b_data = d[6:0]; b_podd = podd; b_valid = 1'b1; end
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      r = (ch == 0) ? a_ready : b_ready;
      @(posedge clk);
      if (r) acc = 1'b1;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: ch%0d word 0x%0h never accepted", ch, d);
    end else begin
      t = longint'($time);
      if (expect_frame) begin
        e.ch = ch;
        e.frame = (ch == 0) ? build({1'b0, d}, 8, par, 1, n) : build({2'b0, d[6:0]}, 7, par, 2, n);
        e.nbits = n;
        e.acc_t = t;
        sb.push_back(e);
      end
    end
    #1;
    if (!keep) begin
      if (ch == 0) begin a_valid = 1'b0; a_data = ~d; end
      else begin b_valid = 1'b0; b_data = ~d[6:0]; end
    end
  endtask

  task automatic wait_idle(input int ch);
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 500 && !idle; c++) begin
      @(negedge clk);
      idle = (ch == 0) ? !a_busy : !b_busy;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL idle_timeout: ch%0d still busy", ch);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    longint t1, t2, tx_unused;
    int d0;
    clear_mon(0); clear_mon(1);
    dones[0] = 0; dones[1] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tx_a", a_tx, 1);      check("rst_ready_a", a_ready, 1);
    check("rst_busy_a", a_busy, 0);  check("rst_done_a", a_done, 0);
    check("rst_tx_b", b_tx, 1);      check("rst_ready_b", b_ready, 1);
    check("rst_busy_b", b_busy, 0);  check("rst_done_b", b_done, 0);
    @(posedge clk); #1;

    // 0xA5 has four ones: even parity bit 0, odd parity bit 1.
    offer(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, t1); wait_idle(0);
    offer(0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, t1); wait_idle(0);

    // tx_valid held across two words: second START must follow the first tx_done directly.
    offer(0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, t1);
    offer(0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, t2);
    check("b2b_accept_spacing", (t2 - t1) / 10, (10 + PAR) * CPB);
    @(negedge clk);
    check("b2b_start_tx", a_tx, 0);
    check("b2b_start_busy", a_busy, 1);
    wait_idle(0);

    // tx_data is inverted right after acceptance; the frame must carry 0x3C.
    offer(0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, t1);
    repeat (10) @(posedge clk);
    #1 a_data = 8'h00;
    wait_idle(0);

    // Abort in data bit 3 (cycles 17..20 after acceptance).
    d0 = dones[0];
    offer(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, tx_unused);
    repeat (17) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_tx", a_tx, 1);       check("abort_ready", a_ready, 1);
    check("abort_busy", a_busy, 0);   check("abort_done", a_done, 0);
    repeat (60) @(posedge clk);
    check("abort_no_done", dones[0] - d0, 0);
    #1;
    offer(0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, t1); wait_idle(0);

    // 7 data bits, 2 stop bits: 0x7F -> even parity 1; 0x2A has three ones -> odd parity 0.
    offer(1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, t1); wait_idle(1);
    offer(1, 8'h2A, 1'b1, 1'b0, 1'b0, 1'b1, t1); wait_idle(1);

    for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk);
    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_done: ch%0d frame 0x%0h never completed", sb[0].ch, sb[0].frame);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
